// File: rtl/spi_mem_pkg.sv
// -----------------------------------------------------------------------------
// spi_mem_pkg
// Shared types and constants for the SPI memory slave controller.
//   spi_state_t : transaction state encoding
//   RW_READ / RW_WRITE : encoding of the R/W bit that closes the header
//   max_int     : elaboration-time helper for sizing the bit counter
// Configuration macro: SPI_FSM_BURST_EN (adds READ_INC for burst reads).
// -----------------------------------------------------------------------------
package spi_mem_pkg;

    typedef enum logic [3:0] {
        IDLE,
        GET_HDR,
        GOT_HDR,
        WRITE,
        WR_COMMIT,
`ifdef SPI_FSM_BURST_EN
        READ_INC,
`endif
        READ_LOAD,
        READ_SHIFT,
        DONE
    } spi_state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// -----------------------------------------------------------------------------
// spi_bit_counter
// Counts SCLK rising-edge strobes within one header or data frame.
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   clear      : synchronous clear (state entry); wins over en
//   en         : one-clk strobe to count
//   term       : number of strobes that make up the current frame
//   last       : the strobe presented this cycle completes the frame
// -----------------------------------------------------------------------------
module spi_bit_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] term,
    output logic             last
);

    logic [WIDTH-1:0] count;

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge value of every other flop, independent of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

    // Combinational so the FSM can leave the counting state on the very edge
    // that samples the final strobe.
    assign last = en && (count == term - WIDTH'(1));

endmodule

// File: rtl/spi_mem_fsm.sv
// -----------------------------------------------------------------------------
// spi_mem_fsm
// SPI-slave transaction controller: header capture, data-memory write,
// shift-register load and MISO readout, with abort on chip-select release.
// Parameters:
//   ADDR_BITS : address field width (header = ADDR_BITS + 1 bits, last is R/W)
//   DATA_BITS : data frame width
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   sclk_rise  : one-clk strobe per SCLK rising edge
//   cs         : conditioned chip select, active low
//   rw_bit     : shift-register serial bit, read as R/W in GOT_HDR
//   addr_we    : address latch write enable
//   dm_we      : data memory write enable
//   sr_we      : shift-register parallel load enable
//   miso_bufe  : MISO tri-state buffer enable
//   addr_inc   : address latch increment (burst builds only)
// Configuration macro: SPI_FSM_BURST_EN enables burst transfers with address
// auto-increment; without it every transaction ends in DONE.
// -----------------------------------------------------------------------------
module spi_mem_fsm
    import spi_mem_pkg::*;
#(
    parameter int ADDR_BITS = 7,
    parameter int DATA_BITS = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic sclk_rise,
    input  logic cs,
    input  logic rw_bit,
    output logic addr_we,
    output logic dm_we,
    output logic sr_we,
    output logic miso_bufe,
    output logic addr_inc
);

    localparam int HDR_BITS = ADDR_BITS + 1;
    localparam int CNT_W    = $clog2(max_int(HDR_BITS, DATA_BITS) + 1);

    spi_state_t state_q, state_d;
    logic       cnt_last;
    logic       cnt_en;
    logic       cnt_clear;
    logic [CNT_W-1:0] cnt_term;
    logic addr_we_d, dm_we_d, sr_we_d, miso_bufe_d, addr_inc_d;

    // Strobes are only counted in the multi-cycle shifting states; the
    // single-cycle states and DONE ignore them.
    assign cnt_en    = sclk_rise && (state_q inside {GET_HDR, WRITE, READ_SHIFT});
    assign cnt_clear = (state_d != state_q);
    assign cnt_term  = (state_q == GET_HDR) ? CNT_W'(HDR_BITS) : CNT_W'(DATA_BITS);

    spi_bit_counter #(
        .WIDTH (CNT_W)
    ) u_bit_counter (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .en    (cnt_en),
        .term  (cnt_term),
        .last  (cnt_last)
    );

    // State and output registers. Outputs are decoded from the next state so
    // each strobe lines up with the cycle its state is resident.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_we   <= 1'b0;
            dm_we     <= 1'b0;
            sr_we     <= 1'b0;
            miso_bufe <= 1'b0;
            addr_inc  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_we   <= addr_we_d;
            dm_we     <= dm_we_d;
            sr_we     <= sr_we_d;
            miso_bufe <= miso_bufe_d;
            addr_inc  <= addr_inc_d;
        end
    end

    // Next-state logic. Chip-select release overrides everything, including a
    // final-bit strobe in the same cycle, so a partial write never commits.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        if (cs) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:       state_d = GET_HDR;
                GET_HDR:    if (cnt_last) state_d = GOT_HDR;
                GOT_HDR:    state_d = (rw_bit == RW_READ) ? READ_LOAD : WRITE;
                WRITE:      if (cnt_last) state_d = WR_COMMIT;
`ifdef SPI_FSM_BURST_EN
                // cs is known low here, so the burst continues.
                WR_COMMIT:  state_d = WRITE;
                READ_INC:   state_d = READ_LOAD;
                READ_SHIFT: if (cnt_last) state_d = READ_INC;
`else
                WR_COMMIT:  state_d = DONE;
                READ_SHIFT: if (cnt_last) state_d = DONE;
`endif
                READ_LOAD:  state_d = READ_SHIFT;
                DONE:       state_d = DONE;
                default:    state_d = IDLE;
            endcase
        end
    end

    // Output decode from the next state.
    always_comb begin
        addr_we_d   = (state_d == GOT_HDR);
        dm_we_d     = (state_d == WR_COMMIT);
        sr_we_d     = (state_d == READ_LOAD);
        miso_bufe_d = (state_d == READ_SHIFT);
`ifdef SPI_FSM_BURST_EN
        // Write: increment alongside the commit. Read: increment one clk
        // before the reload so the shift register sees the new address.
        addr_inc_d  = (state_d == WR_COMMIT) || (state_d == READ_INC);
`else
        addr_inc_d  = 1'b0;
`endif
    end

endmodule

// File: doc/spi_mem_fsm.md
# spi_mem_fsm

Parametrised SPI-slave transaction controller for the SPI memory datapath. It sequences header capture, data-memory write, and shift-register load/readout from conditioned chip-select and single-cycle SCLK edge strobes. Generalised in address and data width. Adds burst transfers with address auto-increment and abort on chip-select deassertion mid-transaction. It sits between the input conditioners and the address latch, data memory, shift register and MISO buffer.

## Interface
- ADDR_BITS, default 7: address field width; header is ADDR_BITS+1 bits, the last being R/W.
- DATA_BITS, default 8: data frame width.
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high; forces IDLE and clears all outputs and counters.
- sclk_rise  in  1  one-clk strobe per SCLK rising edge, from the conditioner.
- cs  in  1  conditioned chip select, active low.
- rw_bit  in  1  shift-register serial bit; valid as R/W in GOT_HDR (1 = read, 0 = write).
- addr_we  out  1  address latch write enable.
- dm_we  out  1  data memory write enable.
- sr_we  out  1  shift-register parallel load enable.
- miso_bufe  out  1  MISO tri-state buffer enable.
- addr_inc  out  1  address latch increment (burst only).

## Operation
- Moore machine. Outputs are registered and decoded from the next state, so they align with the state they belong to. All outputs reset to 0.
- IDLE: all outputs 0; bit counter cleared. If cs==0 → GET_HDR.
- GET_HDR: count sclk_rise; on the (ADDR_BITS+1)th strobe → GOT_HDR.
- GOT_HDR (1 clk): addr_we=1. Next: rw_bit==1 → READ_LOAD, else → WRITE.
- WRITE: count sclk_rise; on the DATA_BITSth strobe → WR_COMMIT.
- WR_COMMIT (1 clk): dm_we=1. Next → DONE, or → WRITE with burst (see Configuration).
- READ_LOAD (1 clk): sr_we=1. Next → READ_SHIFT.
- READ_SHIFT: miso_bufe=1; count sclk_rise; on the DATA_BITSth strobe → DONE, or → READ_LOAD with burst.
- DONE: all outputs 0; cs==1 → IDLE. Further strobes are ignored.
- Abort: cs==1 in any state other than IDLE → IDLE on the next clk; the counter clears and every output is 0 in that cycle. An incomplete write never asserts dm_we. Abort takes priority over a simultaneous final-bit strobe.
- Bit counter width is $clog2(max(ADDR_BITS+1, DATA_BITS)+1). It clears on every state entry.

## Timing
- Header to addr_we: addr_we is high for exactly the clk following the clk that sampled the last header strobe.
- R/W is sampled once, in the GOT_HDR cycle.
- Write latency: dm_we asserts 1 clk after the last data strobe, for 1 clk.
- Read: sr_we asserts 1 clk after addr_we (2 clk after the last header strobe). miso_bufe asserts on the following clk and holds until the DATA_BITSth strobe.
- Strobes arriving during single-clk states (GOT_HDR, WR_COMMIT, READ_LOAD) are not counted. The conditioner guarantees at least 3 clk between strobes.
- Reset is asynchronous at any point: outputs drop to 0 immediately without waiting for a clk edge.

## Configuration
- SPI_FSM_BURST_EN defined:
  - WR_COMMIT with cs==0 → WRITE, with addr_inc=1 during WR_COMMIT (same cycle as dm_we; the latch increments after the write).
  - READ_SHIFT completion with cs==0 → READ_LOAD, with addr_inc=1 for 1 clk on entry to READ_LOAD, so the load happens the clk after the increment (sr_we delayed 1 clk via a READ_INC state).
- Undefined: addr_inc is tied to 0, READ_INC does not exist, and every transaction ends in DONE.

## Structure
- Shared package spi_mem_pkg: state enum (IDLE, GET_HDR, GOT_HDR, WRITE, WR_COMMIT, READ_INC, READ_LOAD, READ_SHIFT, DONE) and R/W encoding constants RW_READ=1, RW_WRITE=0.
- One sub-module: spi_bit_counter (parametrised width; clear, strobe-enable, terminal-count compare output).

## Test plan
- Write, ADDR_BITS=7, DATA_BITS=8: cs low, 8 header strobes with rw=0, 8 data strobes → addr_we one clk after header strobe 8; dm_we one clk after data strobe 8; DONE; IDLE after cs high.
- Read: header with rw=1 → addr_we, then sr_we the next clk, then miso_bufe high for exactly 8 strobes, then 0 in DONE.
- Abort: cs high after 5 write-data strobes → IDLE next clk; dm_we never asserts; all outputs 0.
- Burst, macro defined: 3 write frames with cs held low → 3 dm_we pulses, each with addr_inc in the same clk. Read burst of 2 frames → addr_inc precedes the second sr_we by 1 clk.
- Burst, macro undefined: extra strobes after the first frame are ignored in DONE; addr_inc stays 0.
- Reset mid-READ_SHIFT (async, between clk edges) → miso_bufe drops immediately; IDLE after reset release; a new transaction then completes normally.
